// File: rtl/ci_pipeline_driver.sv
// Initiator-side driver for a fixed-latency pipelined custom-instruction datapath:
// input FIFO, credit-gated issue, in-flight tag shift register and a show-ahead result FIFO.
module ci_pipeline_driver #(
  parameter int LATENCY = 16,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ci_clk_en,
  output logic [WIDTH-1:0] ci_dataa,
  output logic             ci_reset,
  input  logic [WIDTH-1:0] ci_result,
  output logic             busy
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int TW  = $clog2(LATENCY + 1);
  localparam int OSW = $clog2(DEPTH + LATENCY + 1);

  logic [WIDTH-1:0]   in_mem  [DEPTH];
  logic [WIDTH-1:0]   out_mem [DEPTH];

  logic [AW-1:0]      in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [AW-1:0]      out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [TW-1:0]      tag_cnt_q, tag_cnt_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic               in_ready_q, in_ready_d;

  logic [OSW-1:0]     outstanding;
  logic               in_push, issue, clk_en, capture, out_pop;

  always_comb begin
    // Credits cover every result that could still land, so a capture always finds room.
    outstanding = OSW'(tag_cnt_q) + OSW'(out_cnt_q);
    in_push     = in_valid && in_ready_q && !flush;
    issue       = (in_cnt_q != '0) && (outstanding < OSW'(DEPTH)) && !flush;
    clk_en      = issue || (tag_cnt_q != '0);
    capture     = clk_en && tag_q[LATENCY-1] && !flush;
    out_pop     = (out_cnt_q != '0) && out_ready && !flush;

    in_wr_d     = in_wr_q + AW'(in_push);
    in_rd_d     = in_rd_q + AW'(issue);
    in_cnt_d    = in_cnt_q + CW'(in_push) - CW'(issue);
    out_wr_d    = out_wr_q + AW'(capture);
    out_rd_d    = out_rd_q + AW'(out_pop);
    out_cnt_d   = out_cnt_q + CW'(capture) - CW'(out_pop);
    tag_d       = clk_en ? {tag_q[LATENCY-2:0], issue} : tag_q;
    tag_cnt_d   = tag_cnt_q + TW'(issue) - TW'(capture);
    in_ready_d  = (in_cnt_d != CW'(DEPTH));

    if (flush) begin
      in_wr_d    = '0;
      in_rd_d    = '0;
      in_cnt_d   = '0;
      out_wr_d   = '0;
      out_rd_d   = '0;
      out_cnt_d  = '0;
      tag_d      = '0;
      tag_cnt_d  = '0;
      in_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      tag_q      <= '0;
      tag_cnt_q  <= '0;
      in_ready_q <= 1'b0;
    end else begin
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      tag_q      <= tag_d;
      tag_cnt_q  <= tag_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (capture) out_mem[out_wr_q] <= ci_result;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (out_cnt_q != '0);
  assign out_data  = out_valid ? out_mem[out_rd_q] : '0;
  assign ci_clk_en = clk_en;
  assign ci_dataa  = issue ? in_mem[in_rd_q] : '0;
  assign ci_reset  = !reset || flush;
  assign busy      = (in_cnt_q != '0) || (out_cnt_q != '0) || (tag_cnt_q != '0);

endmodule

// File: tb/tb_ci_pipeline_driver.sv
// Self-checking bench for ci_pipeline_driver: behavioural datapath model plus an
// operand-order scoreboard; table-driven burst, hand sequences and a random phase.
module tb_ci_pipeline_driver;
  localparam int LAT = 16;
  localparam int DEP = 16;
  localparam int W   = 32;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         ci_clk_en;
  logic [W-1:0] ci_dataa;
  logic         ci_reset;
  logic [W-1:0] ci_result;
  logic         busy;

  ci_pipeline_driver #(.LATENCY(LAT), .DEPTH(DEP), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ci_clk_en(ci_clk_en), .ci_dataa(ci_dataa), .ci_reset(ci_reset),
    .ci_result(ci_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: known operand/result pairs, otherwise x+1; or identity when selected.
  logic dp_identity;

  function automatic logic [W-1:0] dp_func(input logic [W-1:0] x);
    case (x)
      32'h41c80000: return 32'h43deea9d;
      32'h42480000: return 32'h4501b0c0;
      32'h437a0000: return 32'h470de056;
      default:      return x + 32'd1;
    endcase
  endfunction

  // Result of the operand sampled at enabled edge n is visible after enabled edge n+LAT-1.
  logic [W-1:0] dp_stage [LAT];
  always @(posedge clk) begin
    if (ci_reset) begin
      for (int i = 0; i < LAT; i++) dp_stage[i] <= '0;
    end else if (ci_clk_en) begin
      dp_stage[0] <= dp_identity ? ci_dataa : dp_func(ci_dataa);
      for (int i = 1; i < LAT; i++) dp_stage[i] <= dp_stage[i-1];
    end
  end
  assign ci_result = dp_stage[LAT-1];

  int           n_vec;
  int           n_err;
  logic [W-1:0] ref_q [$];
  logic [W-1:0] out_log [64];
  int           out_n;
  int           en_cyc;
  int           en_rise;
  logic         en_prev;

  typedef struct {
    logic [W-1:0] op;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Sampled on the falling edge; decisions describe what the next rising edge will do.
  task automatic monitor();
    logic [W-1:0] exp;
    if (ci_clk_en) begin
      en_cyc++;
      if (!en_prev) en_rise++;
    end
    en_prev = ci_clk_en;
    if (reset && ref_q.size() == 0) begin
      n_vec++;
      if (busy !== 1'b0 || ci_clk_en !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_quiet: busy=%b clk_en=%b out_valid=%b required 0 0 0",
                 busy, ci_clk_en, out_valid);
      end
    end
    if (!reset || flush) begin
      ref_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (ref_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_output: got %h required no output", out_data);
        end else begin
          exp = ref_q.pop_front();
          $display("out #%0d data=%h expected=%h", out_n, out_data, exp);
          if (out_data !== exp) begin
            n_err++;
            $display("FAIL out_data: got %h required %h", out_data, exp);
          end
        end
        if (out_n < 64) out_log[out_n] = out_data;
        out_n++;
      end
      if (in_valid && in_ready)
        ref_q.push_back(dp_identity ? in_data : dp_func(in_data));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i <= 200; i++) begin
      if (in_ready) begin
        tick();
        break;
      end
      if (i == 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready low for 200 cycles, word %h", w);
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i;
    i = 0;
    while (ref_q.size() != 0 && i < bound) begin
      tick();
      i++;
    end
    n_vec++;
    if (ref_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, required 0", name, ref_q.size(), bound);
    end
    tick();
    tick();
  endtask

  initial begin
    int first_k;
    int sent;
    int cyc;
    logic [W-1:0] first_d;

    tbl[0]  = '{32'h00000000, 32'h00000001};
    tbl[1]  = '{32'h3f800000, 32'h3f800001};
    tbl[2]  = '{32'h40000000, 32'h40000001};
    tbl[3]  = '{32'h40a00000, 32'h40a00001};
    tbl[4]  = '{32'h41200000, 32'h41200001};
    tbl[5]  = '{32'h41c80000, 32'h43deea9d};
    tbl[6]  = '{32'h42480000, 32'h4501b0c0};
    tbl[7]  = '{32'h42c80000, 32'h42c80001};
    tbl[8]  = '{32'h43160000, 32'h43160001};
    tbl[9]  = '{32'h43480000, 32'h43480001};
    tbl[10] = '{32'h437a0000, 32'h470de056};

    n_vec = 0; n_err = 0; out_n = 0; en_cyc = 0; en_rise = 0; en_prev = 1'b0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    dp_identity = 1'b0;

    #2;
    chk("rst_in_ready",  W'(in_ready),  '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data",  out_data,      '0);
    chk("rst_clk_en",    W'(ci_clk_en), '0);
    chk("rst_dataa",     ci_dataa,      '0);
    chk("rst_ci_reset",  W'(ci_reset),  W'(1));
    chk("rst_busy",      W'(busy),      '0);
    tick(); tick();
    #2 reset = 1'b1;
    #1 chk("in_ready_before_edge", W'(in_ready), '0);
    chk("ci_reset_released", W'(ci_reset), '0);
    tick();
    chk("in_ready_after_edge", W'(in_ready), W'(1));

    // Single operand: out_valid first observed after edge e0+LAT+1.
    out_ready = 1'b1;
    out_n = 0;
    in_valid = 1'b1;
    in_data  = 32'h41c80000;
    tick();
    in_valid = 1'b0;
    first_k = -1;
    first_d = '0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (out_valid && first_k < 0) begin
        first_k = k;
        first_d = out_data;
      end
    end
    chk("single_latency", W'(first_k), W'(LAT + 1));
    chk("single_data", first_d, 32'h43deea9d);
    chk("single_count", W'(out_n), W'(1));
    chk("single_busy_idle", W'(busy), '0);

    // Full-rate burst from the vector table.
    out_n = 0; en_cyc = 0; en_rise = 0;
    for (int i = 0; i < 11; i++) send(tbl[i].op);
    wait_drain(200, "burst_drain");
    chk("burst_count", W'(out_n), W'(11));
    for (int i = 0; i < 11; i++) chk("burst_vec", out_log[i], tbl[i].exp);
    chk("burst_en_cycles", W'(en_cyc), W'(11 + LAT));
    chk("burst_en_contiguous", W'(en_rise), W'(1));

    // Backpressure: 16 credits plus 16 buffered, then the stream stalls.
    dp_identity = 1'b1;
    out_ready = 1'b0;
    out_n = 0;
    for (int w = 0; w < 32; w++) send(W'(w));
    in_valid = 1'b1;
    in_data  = W'(32);
    repeat (40) tick();
    chk("bp_in_ready", W'(in_ready), '0);
    chk("bp_clk_en_low", W'(ci_clk_en), '0);
    chk("bp_out_valid", W'(out_valid), W'(1));
    chk("bp_busy", W'(busy), W'(1));
    out_ready = 1'b1;
    for (int w = 32; w < 40; w++) send(W'(w));
    wait_drain(300, "bp_drain");
    chk("bp_count", W'(out_n), W'(40));
    for (int i = 0; i < 40; i++) chk("bp_order", out_log[i], W'(i));

    // Flush with work in flight and buffered; the beat presented on the flush edge is dropped.
    for (int w = 100; w < 106; w++) send(W'(w));
    chk("flush_busy_before", W'(busy), W'(1));
    in_valid = 1'b1;
    in_data  = W'(999);
    flush    = 1'b1;
    #1 chk("flush_ci_reset", W'(ci_reset), W'(1));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy_after", W'(busy), '0);
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_in_ready", W'(in_ready), W'(1));
    repeat (30) tick();
    dp_identity = 1'b0;
    out_n = 0;
    send(32'h42480000);
    wait_drain(100, "flush_after_drain");
    chk("flush_after_count", W'(out_n), W'(1));
    chk("flush_after_data", out_log[0], 32'h4501b0c0);

    // Asynchronous reset between edges in the middle of a burst.
    dp_identity = 1'b1;
    for (int w = 200; w < 210; w++) send(W'(w));
    #2 reset = 1'b0;
    #1;
    chk("arst_in_ready",  W'(in_ready),  '0);
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_out_data",  out_data,      '0);
    chk("arst_clk_en",    W'(ci_clk_en), '0);
    chk("arst_dataa",     ci_dataa,      '0);
    chk("arst_ci_reset",  W'(ci_reset),  W'(1));
    chk("arst_busy",      W'(busy),      '0);
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    out_n = 0;
    send(W'(77));
    wait_drain(100, "arst_after_drain");
    chk("arst_after_count", W'(out_n), W'(1));
    chk("arst_after_data", out_log[0], W'(77));

    // Random valid/ready at 50% against the scoreboard.
    out_n = 0;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_sent", W'(sent), W'(1000));
    out_ready = 1'b1;
    wait_drain(500, "rand_drain");
    chk("rand_count", W'(out_n), W'(1000));
    chk("rand_busy_idle", W'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
